// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: pipelined IEEE-754-style multiplier with valid/ready handshake, RNE rounding, FTZ and exception flags
//   clk, nrst (sync, active-low)
//   in_valid/in_ready, in_a, in_b, in_tag : operand pair and its destination tag
//   out_valid/out_ready, out_result, out_tag, out_flags {invalid, overflow, underflow, inexact}
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     in_a,
  input  logic [EXP_W+MAN_W:0]     in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic [3:0]               out_flags
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam int BIAS = 2 ** (EXP_W - 1) - 1;
  localparam int EMAX = 2 ** EXP_W - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic stall;
  assign stall = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // unpack and classify; exp=0 is flushed to zero
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, nan_any, inf_any, zero_any, sgn;
  logic [W-1:0] sres;
  logic sinv;
  assign ea = in_a[W-2:MAN_W];
  assign eb = in_b[W-2:MAN_W];
  assign fa = in_a[MAN_W-1:0];
  assign fb = in_b[MAN_W-1:0];
  assign nan_a = (&ea) & (|fa);
  assign nan_b = (&eb) & (|fb);
  assign inf_a = (&ea) & ~(|fa);
  assign inf_b = (&eb) & ~(|fb);
  assign zero_a = ~(|ea);
  assign zero_b = ~(|eb);
  assign nan_any = nan_a | nan_b;
  assign inf_any = inf_a | inf_b;
  assign zero_any = zero_a | zero_b;
  assign sgn = in_a[W-1] ^ in_b[W-1];
  assign sres = (nan_any | (inf_any & zero_any)) ? QNAN :
                inf_any ? {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sgn, {(W-1){1'b0}}};
  // a quiet NaN propagates silently; only a signalling NaN or inf*0 raises invalid
  assign sinv = nan_any ? ((nan_a & ~fa[MAN_W-1]) | (nan_b & ~fb[MAN_W-1])) : (inf_any & zero_any);

  logic v1, v2, v3;
  logic s1_sgn, s2_sgn, s3_sgn;
  logic [EW-1:0] s1_e, s2_e, s3_e;
  logic [MAN_W:0] s1_ma, s1_mb, s3_sig;
  logic [PW-1:0] s2_p;
  logic s1_spec, s2_spec, s3_spec, s1_sinv, s2_sinv, s3_sinv, s3_g, s3_st;
  logic [W-1:0] s1_sres, s2_sres, s3_sres;
  logic [TAG_W-1:0] s1_tag, s2_tag, s3_tag;

  // normalise: a product >= 2.0 has its MSB set and bumps the exponent
  logic msb;
  logic [PW-1:0] pn;
  assign msb = s2_p[PW-1];
  assign pn = msb ? s2_p : s2_p << 1;

  // round to nearest even; a carry out of the significand renormalises
  logic up, c, ovf, unf;
  logic [MAN_W+1:0] sr;
  logic [MAN_W-1:0] frac;
  logic [EW-1:0] ef;
  logic [W-1:0] res;
  logic [3:0] flags;
  assign up = s3_g & (s3_st | s3_sig[0]);
  assign sr = {1'b0, s3_sig} + (MAN_W+2)'(up);
  assign c = sr[MAN_W+1];
  assign frac = c ? sr[MAN_W:1] : sr[MAN_W-1:0];
  assign ef = s3_e + EW'(c);
  assign ovf = ~ef[EW-1] & (ef[EW-2:0] >= (EW-1)'(EMAX));
  assign unf = ef[EW-1] | ~(|ef);
  assign res = s3_spec ? s3_sres :
               ovf ? {s3_sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
               unf ? {s3_sgn, {(W-1){1'b0}}} : {s3_sgn, ef[EXP_W-1:0], frac};
  assign flags = s3_spec ? {s3_sinv, 3'b000} : ovf ? 4'b0101 : unf ? 4'b0011 : {3'b000, s3_g | s3_st};

  always_ff @(posedge clk) begin
    if (!nrst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      out_valid <= 1'b0;
      out_result <= '0;
      out_tag <= '0;
      out_flags <= '0;
    end else if (!stall) begin
      v1 <= in_valid;
      s1_sgn <= sgn;
      s1_e <= {2'b00, ea} + {2'b00, eb} - EW'(BIAS);
      s1_ma <= {1'b1, fa};
      s1_mb <= {1'b1, fb};
      s1_spec <= nan_any | inf_any | zero_any;
      s1_sres <= sres;
      s1_sinv <= sinv;
      s1_tag <= in_tag;
      v2 <= v1;
      s2_sgn <= s1_sgn;
      s2_e <= s1_e;
      s2_p <= s1_ma * s1_mb;
      s2_spec <= s1_spec;
      s2_sres <= s1_sres;
      s2_sinv <= s1_sinv;
      s2_tag <= s1_tag;
      v3 <= v2;
      s3_sgn <= s2_sgn;
      s3_e <= s2_e + EW'(msb);
      s3_sig <= pn[PW-1:MAN_W+1];
      s3_g <= pn[MAN_W];
      s3_st <= |pn[MAN_W-1:0];
      s3_spec <= s2_spec;
      s3_sres <= s2_sres;
      s3_sinv <= s2_sinv;
      s3_tag <= s2_tag;
      out_valid <= v3;
      out_result <= res;
      out_tag <= s3_tag;
      out_flags <= flags;
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed checks of fp_mul_pipe in single and half precision
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  logic nrst;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_result;
  logic [3:0] in_tag, out_tag, out_flags;
  logic h_in_valid, h_in_ready, h_out_valid;
  logic [15:0] h_in_a, h_in_b, h_out_result;
  logic [3:0] h_in_tag, h_out_tag, h_out_flags;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_mul_pipe dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag), .out_flags(out_flags)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_h (
    .clk(clk), .nrst(nrst), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_a(h_in_a), .in_b(h_in_b), .in_tag(h_in_tag), .out_valid(h_out_valid),
    .out_ready(1'b1), .out_result(h_out_result), .out_tag(h_out_tag), .out_flags(h_out_flags)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                    input logic [31:0] er, input logic [3:0] ef);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = t;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 3);
    chk("result", out_result, er);
    chk("tag", out_tag, t);
    chk("flags", out_flags, ef);
  endtask

  task automatic op_h(input logic [15:0] a, input logic [15:0] b, input logic [3:0] t,
                      input logic [15:0] er, input logic [3:0] ef);
    int n;
    @(negedge clk);
    h_in_valid = 1'b1; h_in_a = a; h_in_b = b; h_in_tag = t;
    @(negedge clk);
    h_in_valid = 1'b0;
    n = 0;
    while (!h_out_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("h_latency", n, 3);
    chk("h_result", h_out_result, er);
    chk("h_tag", h_out_tag, t);
    chk("h_flags", h_out_flags, ef);
  endtask

  logic [31:0] bp_a [4] = '{32'h40400000, 32'h3FC00000, 32'h3F800800, 32'hFF800000};
  logic [31:0] bp_b [4] = '{32'h40000000, 32'h3FC00000, 32'h3F800800, 32'h40000000};
  logic [31:0] bp_r [4] = '{32'h40C00000, 32'h40100000, 32'h3F801000, 32'hFF800000};
  logic [3:0]  bp_f [4] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000};

  initial begin
    int seen;
    nrst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0; in_tag = '0;
    h_in_valid = 1'b0; h_in_a = '0; h_in_b = '0; h_in_tag = '0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_result", out_result, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_flags", out_flags, 0);
    chk("rst_h_valid", h_out_valid, 0);

    op(32'h40400000, 32'h40000000, 4'd5, 32'h40C00000, 4'b0000);
    op(32'h3FC00000, 32'h3FC00000, 4'd6, 32'h40100000, 4'b0000);
    op(32'h3F800800, 32'h3F800800, 4'd7, 32'h3F801000, 4'b0001);
    op(32'h3F800001, 32'h3F800001, 4'd8, 32'h3F800002, 4'b0001);
    op(32'h7F000000, 32'h7F000000, 4'd9, 32'h7F800000, 4'b0101);
    op(32'h00800000, 32'h3F000000, 4'd10, 32'h00000000, 4'b0011);
    op(32'h7F800000, 32'h00000000, 4'd11, 32'h7FC00000, 4'b1000);
    op(32'hFF800000, 32'h40000000, 4'd12, 32'hFF800000, 4'b0000);
    op(32'h7F800001, 32'h3F800000, 4'd13, 32'h7FC00000, 4'b1000);
    op(32'h7FC00000, 32'h3F800000, 4'd14, 32'h7FC00000, 4'b0000);
    op(32'hC0000000, 32'h00000000, 4'd15, 32'h80000000, 4'b0000);

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = bp_a[i]; in_b = bp_b[i]; in_tag = 4'(i + 1);
      if (i == 1) out_ready = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_valid", out_valid, 1);
    chk("bp_tag1", out_tag, 1);
    chk("bp_in_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_tag", out_tag, 1);
    chk("bp_hold_res", out_result, bp_r[0]);
    chk("bp_hold_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("bp_drain_valid", out_valid, 1);
      chk("bp_drain_tag", out_tag, 4'(i + 1));
      chk("bp_drain_res", out_result, bp_r[i]);
      chk("bp_drain_flags", out_flags, bp_f[i]);
    end
    @(negedge clk);
    chk("bp_empty", out_valid, 0);

    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h40400000; in_b = 32'h40000000; in_tag = 4'd3;
    @(negedge clk);
    in_tag = 4'd4;
    @(negedge clk);
    in_valid = 1'b0; nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mid_rst_stale", seen, 0);

    op_h(16'h4200, 16'h4000, 4'd2, 16'h4600, 4'b0000);
    op_h(16'h7BFF, 16'h4000, 4'd3, 16'h7C00, 4'b0101);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
